act_feeder: RTL
===============

Name: act_feeder

Overview:
- Transmitter end of the superblock activation-input interface. Drives act_data_in / act_data_in_vld and obeys act_data_in_req from one sblk row entry.
- Buffers host-side activation words in a small FIFO.
- Streams exactly cmd_len words per accepted command, then pulses done. The controller instantiates one per sblk row.

Parameters:
- WID_ACT, 16, width of one activation; each word carries 2*WID_ACT bits.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
- WID_LEN, 10, width of the burst-length command field.

Ports:
- clk_l  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- host_data  in  2*WID_ACT  activation word from the host stream.
- host_vld  in  1  host_data valid.
- host_rdy  out  1  FIFO can accept; a push occurs when host_vld & host_rdy.
- cmd_len  in  WID_LEN  number of words to send in a burst.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  high only in IDLE.
- act_data_in  out  2*WID_ACT  word to the sblk, registered.
- act_data_in_vld  out  1  one-cycle strobe per word, registered.
- act_data_in_req  in  1  sblk permission to send, level.
- busy  out  1  high in SEND and DONE.
- done  out  1  one-cycle pulse at end of burst.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - act_data_in = 0, act_data_in_vld = 0, done = 0, busy = 0.
  - FIFO emptied, so host_rdy = 1 after reset.
  - State = IDLE, remaining count = 0.
- FIFO:
  - host_rdy = !full, combinational from occupancy.
  - Push and pop in the same cycle are allowed.
  - When full, host_rdy stays low even if a pop occurs that cycle.
  - No bypass: a word pushed at cycle t can pop no earlier than t+1.
- FSM state IDLE:
  - cmd_rdy = 1.
  - On cmd_vld with cmd_len != 0: latch rem = cmd_len, go to SEND.
  - On cmd_vld with cmd_len == 0: the command is consumed, done pulses the next cycle, state stays IDLE.
- FSM state SEND:
  - A pop occurs in cycle t when act_data_in_req = 1 AND the FIFO is non-empty AND rem != 0.
  - In cycle t+1: act_data_in_vld = 1 and act_data_in = the popped word, so latency is 1 cycle.
  - Otherwise act_data_in_vld = 0 and act_data_in holds its previous value.
  - rem decrements on each pop.
  - The pop that makes rem 0 transitions the FSM to DONE.
  - Stalls, whether from req low or an empty FIFO, are unbounded and lose no words.
- FSM state DONE (one cycle):
  - done = 1; the last word's vld is asserted in this same cycle.
  - Next state is IDLE.
  - Words the host pushes beyond cmd_len remain queued for the next command.
- Req drop: req is sampled at the pop cycle. The sblk must accept at most one word already in flight after it deasserts req.
- Throughput: 1 word/cycle while req stays high and the FIFO stays non-empty.
- cmd_vld in SEND/DONE: ignored, because cmd_rdy = 0.

Optional Feature:
- Macro ACT_FEEDER_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, WID_LEN+8 bits.
  - Counts cycles in SEND where act_data_in_req = 1 but the FIFO is empty.
  - Cleared on rst and on each command accept; saturates at all-ones.
- When undefined: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Package act_feeder_pkg: state enum (IDLE, SEND, DONE), localparam for word width (2*WID_ACT), FIFO pointer-width function ($clog2).
- Sub-module act_fifo: synchronous single-clock FIFO with push/pop/full/empty/count and asynchronous active-high reset.
- FSM, counter and output register live in act_feeder.

Test Plan:
- Reset then cmd_len = 4, 4 words pushed (0xA0..0xA3), req held high -> vld on 4 consecutive cycles with data 0xA0..0xA3; done pulses together with the last vld; cmd_rdy back to 1 the next cycle.
- FIFO_DEPTH = 16, push 20 words with req low -> host_rdy drops after the 16th push; after cmd_len = 20 and req high, all 20 words arrive in order with no loss.
- cmd_len = 3, req toggled 1,0,1,0,1 -> exactly one vld per sampled-high req (3 words total); no vld follows a low-req cycle.
- cmd_len = 0 -> done pulses 1 cycle later; no vld; busy stays 0.
- Assert rst mid-burst after 2 of 5 words -> vld and done drop to 0 immediately; FIFO empty; new cmd_len = 1 with a new word works normally.
- With ACT_FEEDER_STALL_CNT_EN, cmd_len = 2, req high, words pushed 5 cycles late -> stall_cnt = 5 (±1 for the push latency); without the macro, the port is absent.

Source files
------------

// File: rtl/act_feeder_pkg.sv
// Shared types and sizing helpers for the activation feeder.
package act_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WID_ACT_DEF  = 16;
   localparam int WID_WORD_DEF = 2 * WID_ACT_DEF;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/act_fifo.sv
// Single-clock FIFO, no bypass: a pushed word is visible at the head one cycle later.
// Pushes are dropped when full, pops ignored when empty; full/empty/count are registered-state derived.
module act_fifo
   import act_feeder_pkg::*;
#(
   parameter int WIDTH = WID_WORD_DEF,
   parameter int DEPTH = 16
) (
   input  logic                    clk_l,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        pop_data,
   output logic                    full,
   output logic                    empty,
   output logic [ptr_w(DEPTH):0]   count
);

   localparam int PW = ptr_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign full     = (cnt == (PW+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk_l or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   // Storage is left unreset; validity is tracked by the pointers alone.
   always_ff @(posedge clk_l) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/act_feeder.sv
// Streams cmd_len buffered host words to one sblk row, 1-cycle pop-to-vld latency, paced by act_data_in_req.
// Host side stalls on FIFO full; optional stall_cnt port under ACT_FEEDER_STALL_CNT_EN.
module act_feeder
   import act_feeder_pkg::*;
#(
   parameter int WID_ACT    = WID_ACT_DEF,
   parameter int FIFO_DEPTH = 16,
   parameter int WID_LEN    = 10
) (
   input  logic                   clk_l,
   input  logic                   rst,
   input  logic [2*WID_ACT-1:0]   host_data,
   input  logic                   host_vld,
   output logic                   host_rdy,
   input  logic [WID_LEN-1:0]     cmd_len,
   input  logic                   cmd_vld,
   output logic                   cmd_rdy,
   output logic [2*WID_ACT-1:0]   act_data_in,
   output logic                   act_data_in_vld,
   input  logic                   act_data_in_req,
   output logic                   busy,
`ifdef ACT_FEEDER_STALL_CNT_EN
   output logic [WID_LEN+7:0]     stall_cnt,
`endif
   output logic                   done
);

   localparam int WID_WORD = 2 * WID_ACT;
   localparam int CW       = ptr_w(FIFO_DEPTH) + 1;

   state_t               state;
   logic [WID_LEN-1:0]   rem;
   logic [WID_WORD-1:0]  fifo_dat;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CW-1:0]        fifo_count;
   logic                 pop;
   logic                 unused_cnt;

   act_fifo #(
      .WIDTH (WID_WORD),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_l     (clk_l),
      .rst       (rst),
      .push      (host_vld),
      .push_data (host_data),
      .pop       (pop),
      .pop_data  (fifo_dat),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign unused_cnt = ^fifo_count;
   assign host_rdy   = ~fifo_full;
   assign cmd_rdy    = (state == IDLE);
   assign pop        = (state == SEND) & act_data_in_req & ~fifo_empty & (rem != '0);

   always_ff @(posedge clk_l or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         rem             <= '0;
         act_data_in     <= '0;
         act_data_in_vld <= 1'b0;
         done            <= 1'b0;
         busy            <= 1'b0;
      end else begin
         act_data_in_vld <= pop;
         if (pop) act_data_in <= fifo_dat;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_vld) begin
                  if (cmd_len != '0) begin
                     rem   <= cmd_len;
                     state <= SEND;
                     busy  <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (pop) begin
                  rem <= rem - WID_LEN'(1);
                  // Last pop: done lines up with the final word's vld.
                  if (rem == WID_LEN'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ACT_FEEDER_STALL_CNT_EN
   logic stall_hit;
   assign stall_hit = (state == SEND) & act_data_in_req & fifo_empty;

   always_ff @(posedge clk_l or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (cmd_vld & cmd_rdy) begin
         stall_cnt <= '0;
      end else if (stall_hit && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + (WID_LEN+8)'(1);
      end
   end
`endif

endmodule
